bus_lsu: RTL and testbench
==========================

Name: bus_lsu

Overview:
- Bus initiator (load/store unit) that drives the single-cycle rd_en/wr_en peripheral bus used by the memory-mapped peripherals (LED, etc.).
- Accepts one load/store request at a time from the core. Issues word-aligned bus transactions.
- Byte/half stores are done as read-modify-write, because the bus has no byte enables.
- Load data is extracted and extended. Misaligned accesses and missing read responses are reported as errors.

Parameters:
- TIMEOUT, 15: max cycles to wait for bus_rd_valid after the bus_rd_en cycle before an error is flagged (1..255).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  core request present
- req_ready  out  1  LSU can accept request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_signed  in  1  sign-extend load result
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load result (0 for stores/errors)
- resp_err  out  1  misaligned/illegal size/timeout, qualified by resp_valid
- bus_rd_en  out  1  bus read strobe
- bus_wr_en  out  1  bus write strobe
- bus_addr  out  32  word address, {addr[31:2],2'b00}
- bus_wr_data  out  32  bus write data
- bus_rd_data  in  32  peripheral read data
- bus_rd_valid  in  1  peripheral read data valid

Behaviour:
- Reset values: all outputs 0 except req_ready = 1; state IDLE; timeout counter 0.
- Reset mid-transaction abandons the transaction: no resp_valid, strobes drop the next cycle.
- All outputs are registered.
- Handshake:
  - req_ready = 1 only in IDLE.
  - A request is accepted on req_valid && req_ready (cycle T); addr, size, signed, we and wdata are latched.
  - req_ready is low from T+1 until the cycle after resp_valid.
- States: IDLE, ERR, RD, WAIT, WR, RESP.
- Alignment check at accept:
  - half needs addr[0] = 0; word needs addr[1:0] = 0; size 3 is always illegal.
  - On failure go to ERR: no bus strobe; resp_valid = 1, resp_err = 1, resp_rdata = 0 at T+1.
- Load:
  - RD: bus_rd_en = 1 for exactly one cycle (T+1).
  - WAIT: counter counts cycles starting T+2. When bus_rd_valid = 1, capture bus_rd_data.
  - Result: shift right by 8*addr[1:0], mask to size, zero-extend or sign-extend per req_signed. Result in RESP.
  - Nominal peripheral (rd_valid one cycle after rd_en): rd_en T+1, rd_valid T+2, resp_valid T+3.
- Word store: WR drives bus_wr_en = 1 for one cycle at T+1, bus_wr_data = wdata; resp_valid at T+2. Writes have no acknowledge.
- Byte/half store:
  - RD, then WAIT (as for a load).
  - Merge: replace lane(s) at addr[1:0] with wdata[7:0] or wdata[15:0]; other bytes come from the read word.
  - WR with the merged word.
  - Nominal timing: rd_en T+1, rd_valid T+2, wr_en T+3, resp_valid T+4.
- Timeout: if bus_rd_valid is not seen within TIMEOUT WAIT cycles:
  - RESP with resp_err = 1, resp_rdata = 0.
  - A store that times out performs no write.
  - A late bus_rd_valid is ignored.
- bus_rd_valid outside WAIT is ignored. bus_rd_valid in the same cycle as bus_rd_en is ignored (still RD).
- resp_valid is a single-cycle pulse; then IDLE. resp_rdata/resp_err hold until the next response.
- bus_addr holds the latched word address for the whole transaction; 0 in IDLE. bus_wr_data is 0 except during WR.
- bus_rd_en and bus_wr_en are never high in the same cycle.

Test Plan:
- Word load at 0x0000_0004, peripheral returns 0xDEADBEEF one cycle after rd_en -> bus_rd_en high only at T+1, bus_addr = 0x4, resp_valid at T+3 with rdata 0xDEADBEEF, err 0.
- Byte load at 0x7, read word 0x80FF_0000; signed -> 0xFFFF_FF80; unsigned -> 0x0000_0080. Half load at 0x6 signed -> 0xFFFF_80FF.
- Byte store 0xAA at 0x5, read word 0x1122_3344 -> bus_wr_en at T+3 with bus_wr_data 0x1122_AA44, bus_addr 0x4, resp_valid at T+4, err 0.
- Half load at 0x3, word store at 0x2, size 3 -> each gives resp_valid at T+1 with err = 1, rdata 0, and no bus_rd_en/bus_wr_en at any cycle.
- Word load with no bus_rd_valid, TIMEOUT = 15 -> resp_valid with err = 1 at T+17. bus_rd_valid asserted at T+20 is ignored. The next request is accepted normally.
- rst asserted at T+2 of a byte store -> no bus_wr_en and no resp_valid; req_ready = 1 the cycle after rst deasserts. A following word store completes at T+2.

Source files
------------

// File: rtl/bus_lsu_if.sv
// bus_lsu_if: core request/response channel plus the rd_en/wr_en peripheral bus of the LSU.
// Rev 1.0
`default_nettype none

interface bus_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        bus_rd_en;
  logic        bus_wr_en;
  logic [31:0] bus_addr;
  logic [31:0] bus_wr_data;
  logic [31:0] bus_rd_data;
  logic        bus_rd_valid;

  modport master (
    input  req_valid, req_we, req_addr, req_size, req_signed, req_wdata,
    input  bus_rd_data, bus_rd_valid,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output bus_rd_en, bus_wr_en, bus_addr, bus_wr_data
  );

  modport slave (
    output req_valid, req_we, req_addr, req_size, req_signed, req_wdata,
    output bus_rd_data, bus_rd_valid,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  bus_rd_en, bus_wr_en, bus_addr, bus_wr_data
  );
endinterface

`default_nettype wire

// File: rtl/bus_lsu.sv
// bus_lsu: load/store unit driving a word-wide rd_en/wr_en bus; sub-word stores use read-modify-write.
// Rev 1.0
`default_nettype none

module bus_lsu #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  bus_lsu_if.master  lsu
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ERR  = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_WR   = 3'd4;
  localparam logic [2:0] S_RESP = 3'd5;

  localparam logic [7:0] c_last_wait = 8'(TIMEOUT - 1);

  logic [2:0]  r_state;
  logic [1:0]  r_off;
  logic [1:0]  r_size;
  logic        r_signed;
  logic        r_we;
  logic [31:0] r_wdata;
  logic [7:0]  r_cnt;

  logic        w_misaligned;
  logic [4:0]  w_shift;
  logic [31:0] w_shifted;
  logic [31:0] w_load;
  logic [31:0] w_lane_mask;
  logic [31:0] w_ins;
  logic [31:0] w_merged;

  always_comb begin
    w_misaligned = 1'b0;
    case (lsu.req_size)
      2'd1:    w_misaligned = lsu.req_addr[0];
      2'd2:    w_misaligned = |lsu.req_addr[1:0];
      2'd3:    w_misaligned = 1'b1;
      default: w_misaligned = 1'b0;
    endcase
  end

  assign w_shift   = {r_off, 3'b000};
  assign w_shifted = lsu.bus_rd_data >> w_shift;

  always_comb begin
    w_load = w_shifted;
    case (r_size)
      2'd0:    w_load = {{24{r_signed & w_shifted[7]}}, w_shifted[7:0]};
      2'd1:    w_load = {{16{r_signed & w_shifted[15]}}, w_shifted[15:0]};
      default: w_load = w_shifted;
    endcase
  end

  // Sub-word store: new lane(s) over the word just read back
  assign w_lane_mask = ((r_size == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF) << w_shift;
  assign w_ins       = ((r_size == 2'd0) ? {24'd0, r_wdata[7:0]} : {16'd0, r_wdata[15:0]}) << w_shift;
  assign w_merged    = (lsu.bus_rd_data & ~w_lane_mask) | (w_ins & w_lane_mask);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_off           <= 2'd0;
      r_size          <= 2'd0;
      r_signed        <= 1'b0;
      r_we            <= 1'b0;
      r_wdata         <= 32'd0;
      r_cnt           <= 8'd0;
      lsu.req_ready   <= 1'b1;
      lsu.resp_valid  <= 1'b0;
      lsu.resp_rdata  <= 32'd0;
      lsu.resp_err    <= 1'b0;
      lsu.bus_rd_en   <= 1'b0;
      lsu.bus_wr_en   <= 1'b0;
      lsu.bus_addr    <= 32'd0;
      lsu.bus_wr_data <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (lsu.req_valid) begin
            r_off         <= lsu.req_addr[1:0];
            r_size        <= lsu.req_size;
            r_signed      <= lsu.req_signed;
            r_we          <= lsu.req_we;
            r_wdata       <= lsu.req_wdata;
            lsu.req_ready <= 1'b0;
            lsu.bus_addr  <= {lsu.req_addr[31:2], 2'b00};
            if (w_misaligned) begin
              r_state        <= S_ERR;
              lsu.resp_valid <= 1'b1;
              lsu.resp_err   <= 1'b1;
              lsu.resp_rdata <= 32'd0;
            end else if (lsu.req_we && (lsu.req_size == 2'd2)) begin
              r_state         <= S_WR;
              lsu.bus_wr_en   <= 1'b1;
              lsu.bus_wr_data <= lsu.req_wdata;
            end else begin
              r_state       <= S_RD;
              lsu.bus_rd_en <= 1'b1;
            end
          end
        end
        S_RD: begin
          lsu.bus_rd_en <= 1'b0;
          r_cnt         <= 8'd0;
          r_state       <= S_WAIT;
        end
        S_WAIT: begin
          if (lsu.bus_rd_valid) begin
            if (r_we) begin
              r_state         <= S_WR;
              lsu.bus_wr_en   <= 1'b1;
              lsu.bus_wr_data <= w_merged;
            end else begin
              r_state        <= S_RESP;
              lsu.resp_valid <= 1'b1;
              lsu.resp_err   <= 1'b0;
              lsu.resp_rdata <= w_load;
            end
          end else if (r_cnt == c_last_wait) begin
            // Timed out: a pending store is dropped without a write
            r_state        <= S_RESP;
            lsu.resp_valid <= 1'b1;
            lsu.resp_err   <= 1'b1;
            lsu.resp_rdata <= 32'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_WR: begin
          lsu.bus_wr_en   <= 1'b0;
          lsu.bus_wr_data <= 32'd0;
          lsu.resp_valid  <= 1'b1;
          lsu.resp_err    <= 1'b0;
          lsu.resp_rdata  <= 32'd0;
          r_state         <= S_RESP;
        end
        S_ERR, S_RESP: begin
          lsu.resp_valid <= 1'b0;
          lsu.req_ready  <= 1'b1;
          lsu.bus_addr   <= 32'd0;
          r_state        <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bus_lsu.sv
// tb_bus_lsu: randomized load/store traffic against a cycle-indexed behavioural model of the LSU.
// Rev 1.0
`default_nettype none

module tb_bus_lsu;
  localparam int TIMEOUT = 15;
  localparam int NCYC    = 8192;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_lsu_if bif ();

  bus_lsu #(.TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .lsu (bif)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected DUT outputs, indexed by the cycle number they are observed in
  bit          exp_ready [NCYC];
  bit          exp_rd    [NCYC];
  bit          exp_wr    [NCYC];
  logic [31:0] exp_addr  [NCYC];
  logic [31:0] exp_wdata [NCYC];
  bit          exp_rv    [NCYC];
  logic [31:0] exp_rdata [NCYC];
  bit          exp_err   [NCYC];
  bit          pv        [NCYC];
  logic [31:0] pd        [NCYC];
  logic [31:0] mem       [16];

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;
  bit lit_go   = 1'b0;
  bit lit_done = 1'b0;

  logic [31:0] seen_rdata, seen_wdata;
  logic        seen_err;
  int          seen_resp_cyc = 0;
  int          n_rd = 0, n_wr = 0, n_resp = 0;

  string       lit_nm  [$];
  logic [31:0] lit_act [$];
  logic [31:0] lit_exp [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  // Peripheral side: drive the planned read-valid/data pattern
  always @(negedge clk) begin
    bif.bus_rd_valid = pv[cyc];
    bif.bus_rd_data  = pd[cyc];
  end

  // Single compare process: per-cycle model checks, then the pinned literal checks
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("req_ready",   32'(bif.req_ready),  32'(exp_ready[cyc]));
        chk("bus_rd_en",   32'(bif.bus_rd_en),  32'(exp_rd[cyc]));
        chk("bus_wr_en",   32'(bif.bus_wr_en),  32'(exp_wr[cyc]));
        chk("bus_addr",    bif.bus_addr,        exp_addr[cyc]);
        chk("bus_wr_data", bif.bus_wr_data,     exp_wdata[cyc]);
        chk("resp_valid",  32'(bif.resp_valid), 32'(exp_rv[cyc]));
        chk("resp_rdata",  bif.resp_rdata,      exp_rdata[cyc]);
        chk("resp_err",    32'(bif.resp_err),   32'(exp_err[cyc]));
        if (bif.resp_valid === 1'b1) begin
          seen_rdata    = bif.resp_rdata;
          seen_err      = bif.resp_err;
          seen_resp_cyc = cyc;
          n_resp++;
        end
        if (bif.bus_rd_en === 1'b1) n_rd++;
        if (bif.bus_wr_en === 1'b1) begin
          n_wr++;
          seen_wdata = bif.bus_wr_data;
        end
      end
      if (lit_go && !lit_done) begin
        for (int i = 0; i < lit_nm.size(); i++) chk(lit_nm[i], lit_act[i], lit_exp[i]);
        lit_done = 1'b1;
      end
    end
  end

  task automatic pin(input string nm, input logic [31:0] act, input logic [31:0] exp);
    lit_nm.push_back(nm);
    lit_act.push_back(act);
    lit_exp.push_back(exp);
  endtask

  task automatic fill_hold(input int idx, input logic [31:0] rd, input bit er);
    for (int i = idx; i < NCYC; i++) begin
      exp_rdata[i] = rd;
      exp_err[i]   = er;
    end
  endtask

  task automatic junk_req();
    bif.req_valid  = 1'($urandom);
    bif.req_we     = 1'($urandom);
    bif.req_addr   = $urandom;
    bif.req_size   = 2'($urandom);
    bif.req_signed = 1'($urandom);
    bif.req_wdata  = $urandom;
  endtask

  // Issue one request at the current negedge (LSU idle); lat = rd_valid delay after rd_en,
  // lat > TIMEOUT means the peripheral never answers.
  task automatic run_txn(input bit we, input logic [31:0] a, input logic [1:0] sz, input bit sg,
                         input logic [31:0] wd, input int lat, output int base);
    int r, off;
    bit bad;
    logic [31:0] waddr, w, t, res, msk, merged, rrd;
    bit rer;
    base  = cyc + 1;
    waddr = {a[31:2], 2'b00};
    off   = int'(a[1:0]);
    bad   = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    bif.req_valid  = 1'b1;
    bif.req_we     = we;
    bif.req_addr   = a;
    bif.req_size   = sz;
    bif.req_signed = sg;
    bif.req_wdata  = wd;
    rrd = 32'd0;
    rer = 1'b0;
    if (bad) begin
      r   = 1;
      rer = 1'b1;
    end else if (we && sz == 2'd2) begin
      exp_wr[base]    = 1'b1;
      exp_wdata[base] = wd;
      mem[a[5:2]]     = wd;
      r = 2;
    end else begin
      exp_rd[base] = 1'b1;
      w = mem[a[5:2]];
      if (lat > TIMEOUT) begin
        for (int k = 2; k <= TIMEOUT + 1; k++) pv[base + k - 1] = 1'b0;
        r   = TIMEOUT + 2;
        rer = 1'b1;
      end else begin
        for (int k = 2; k <= lat; k++) pv[base + k - 1] = 1'b0;
        pv[base + lat] = 1'b1;
        pd[base + lat] = w;
        if (we) begin
          msk    = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << (8 * off);
          merged = (w & ~msk) | ((wd << (8 * off)) & msk);
          exp_wr[base + lat + 1]    = 1'b1;
          exp_wdata[base + lat + 1] = merged;
          mem[a[5:2]] = merged;
          r = lat + 3;
        end else begin
          t = w >> (8 * off);
          if (sz == 2'd0) begin
            res = t & 32'hFF;
            if (sg && res[7]) res = res | 32'hFFFF_FF00;
          end else if (sz == 2'd1) begin
            res = t & 32'hFFFF;
            if (sg && res[15]) res = res | 32'hFFFF_0000;
          end else begin
            res = t;
          end
          rrd = res;
          r = lat + 2;
        end
      end
    end
    for (int k = 1; k <= r; k++) begin
      exp_ready[base + k - 1] = 1'b0;
      exp_addr[base + k - 1]  = waddr;
    end
    exp_rv[base + r - 1] = 1'b1;
    fill_hold(base + r - 1, rrd, rer);
    @(negedge clk);
    while (cyc <= base + r - 1) begin
      junk_req();
      @(negedge clk);
    end
    bif.req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int b, nr0, nw0, np0, lat;
    bit we;
    logic [1:0] sz;
    logic [31:0] a;

    for (int i = 0; i < NCYC; i++) begin
      exp_ready[i] = 1'b1;
      exp_rd[i]    = 1'b0;
      exp_wr[i]    = 1'b0;
      exp_addr[i]  = 32'd0;
      exp_wdata[i] = 32'd0;
      exp_rv[i]    = 1'b0;
      exp_rdata[i] = 32'd0;
      exp_err[i]   = 1'b0;
      pv[i]        = ($urandom_range(0, 4) == 0);
      pd[i]        = $urandom;
    end
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    bif.req_valid = 1'b0; bif.req_we = 1'b0; bif.req_addr = 32'd0;
    bif.req_size = 2'd0; bif.req_signed = 1'b0; bif.req_wdata = 32'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // Word load, nominal peripheral
    mem[1] = 32'hDEAD_BEEF;
    nr0 = n_rd;
    run_txn(1'b0, 32'h4, 2'd2, 1'b0, 32'd0, 1, b);
    pin("word_load_rdata", seen_rdata, 32'hDEAD_BEEF);
    pin("word_load_err", 32'(seen_err), 32'd0);
    pin("word_load_resp_at", 32'(seen_resp_cyc - b + 1), 32'd3);
    pin("word_load_rd_pulses", 32'(n_rd - nr0), 32'd1);

    // Sub-word load extraction
    mem[1] = 32'h80FF_0000;
    run_txn(1'b0, 32'h7, 2'd0, 1'b1, 32'd0, 1, b);
    pin("byte_load_signed", seen_rdata, 32'hFFFF_FF80);
    run_txn(1'b0, 32'h7, 2'd0, 1'b0, 32'd0, 1, b);
    pin("byte_load_unsigned", seen_rdata, 32'h0000_0080);
    run_txn(1'b0, 32'h6, 2'd1, 1'b1, 32'd0, 1, b);
    pin("half_load_signed", seen_rdata, 32'hFFFF_80FF);

    // Byte store via read-modify-write
    mem[1] = 32'h1122_3344;
    run_txn(1'b1, 32'h5, 2'd0, 1'b0, 32'h0000_00AA, 1, b);
    pin("byte_store_wdata", seen_wdata, 32'h1122_AA44);
    pin("byte_store_resp_at", 32'(seen_resp_cyc - b + 1), 32'd4);
    pin("byte_store_err", 32'(seen_err), 32'd0);

    // Misaligned / illegal requests never touch the bus
    nr0 = n_rd; nw0 = n_wr;
    run_txn(1'b0, 32'h3, 2'd1, 1'b0, 32'd0, 1, b);
    pin("half_mis_err", 32'(seen_err), 32'd1);
    pin("half_mis_resp_at", 32'(seen_resp_cyc - b + 1), 32'd1);
    run_txn(1'b1, 32'h2, 2'd2, 1'b0, 32'h1234_5678, 1, b);
    pin("word_mis_err", 32'(seen_err), 32'd1);
    run_txn(1'b0, 32'h8, 2'd3, 1'b0, 32'd0, 1, b);
    pin("size3_err", 32'(seen_err), 32'd1);
    pin("size3_rdata", seen_rdata, 32'd0);
    pin("illegal_no_strobes", 32'((n_rd - nr0) + (n_wr - nw0)), 32'd0);

    // Timeout, then a late rd_valid that must be ignored
    run_txn(1'b0, 32'h4, 2'd2, 1'b0, 32'd0, TIMEOUT + 1, b);
    pin("timeout_resp_at", 32'(seen_resp_cyc - b + 1), 32'd17);
    pin("timeout_err", 32'(seen_err), 32'd1);
    pv[b + 19] = 1'b1;
    np0 = n_resp;
    while (cyc <= b + 19) @(negedge clk);
    pin("late_valid_no_resp", 32'(n_resp - np0), 32'd0);
    mem[1] = 32'hCAFE_F00D;
    run_txn(1'b0, 32'h4, 2'd2, 1'b0, 32'd0, 1, b);
    pin("after_timeout_load", seen_rdata, 32'hCAFE_F00D);

    // Reset in the middle of a byte store
    mem[1] = 32'h1122_3344;
    nw0 = n_wr; np0 = n_resp;
    b = cyc + 1;
    bif.req_valid = 1'b1; bif.req_we = 1'b1; bif.req_addr = 32'h5;
    bif.req_size = 2'd0; bif.req_signed = 1'b0; bif.req_wdata = 32'hAA;
    exp_rd[b] = 1'b1;
    exp_ready[b] = 1'b0;     exp_addr[b] = 32'h4;
    exp_ready[b + 1] = 1'b0; exp_addr[b + 1] = 32'h4;
    pv[b] = 1'b0; pv[b + 1] = 1'b1; pd[b + 1] = mem[1];
    fill_hold(b + 2, 32'd0, 1'b0);
    @(negedge clk); junk_req();
    @(negedge clk); junk_req(); rst = 1'b1;
    @(negedge clk); junk_req();
    @(negedge clk); rst = 1'b0; bif.req_valid = 1'b0;
    pin("rst_no_write", 32'(n_wr - nw0), 32'd0);
    pin("rst_no_resp", 32'(n_resp - np0), 32'd0);
    run_txn(1'b1, 32'h10, 2'd2, 1'b0, 32'h55AA_1234, 1, b);
    pin("post_rst_store_resp_at", 32'(seen_resp_cyc - b + 1), 32'd2);
    pin("post_rst_store_wdata", seen_wdata, 32'h55AA_1234);

    // Randomized traffic
    for (int t = 0; t < 250 && cyc < NCYC - 100; t++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      we = 1'($urandom);
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      case ($urandom_range(0, 9))
        7, 8:    lat = $urandom_range(2, TIMEOUT);
        9:       lat = TIMEOUT + 1;
        default: lat = 1;
      endcase
      run_txn(we, a, sz, 1'($urandom), $urandom, lat, b);
    end

    lit_go = 1'b1;
    for (int i = 0; i < 10 && !lit_done; i++) @(negedge clk);
    if (!lit_done) begin
      n_errors++;
      $display("FAIL literal_checks actual=not_run expected=run");
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
